imuldiv_int_div_iterative_param: RTL

Parametrised iterative integer divider, restoring radix-2, one quotient bit per cycle. Supports signed and unsigned division with remainder over a configurable operand width W. Sits in the imuldiv unit behind the val/rdy request/response interface used by the mul/div front end. Adds explicit divide-by-zero and signed-overflow semantics and full response backpressure.

---
 rtl/imuldiv_int_div_iterative_param.sv | 128 ++++++++++++
 1 files changed

// File: rtl/imuldiv_int_div_iterative_param.sv
// Iterative restoring radix-2 divider producing one quotient bit per cycle, signed or
// unsigned, with remainder; val/rdy request and response handshakes with backpressure.
module imuldiv_int_div_iterative_param #(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           divreq_msg_fn,
   input  logic [W-1:0]   divreq_msg_a,
   input  logic [W-1:0]   divreq_msg_b,
   input  logic           divreq_val,
   output logic           divreq_rdy,
   output logic [2*W-1:0] divresp_msg_result,
   output logic           divresp_val,
   input  logic           divresp_rdy
);
   localparam int CW = $clog2(W) + 1;
   localparam logic FN_SIGNED = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_r;
   logic [CW-1:0] cnt_r;
   logic          sign_a_r;
   logic          sign_b_r;
   logic          dz_r;
   logic [W-1:0]  b_mag_r;
   logic [W-1:0]  rem_r;
   logic [W-1:0]  q_r;

   logic          sign_a_s;
   logic          sign_b_s;
   logic [W:0]    rem_sh_s;
   logic [W+1:0]  diff_s;
   logic          nonneg_s;
   logic [W-1:0]  rem_next_s;
   logic [W-1:0]  q_next_s;

   function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
      logic [W-1:0] r;
      if (neg) begin
         r = ~v + {{(W-1){1'b0}}, 1'b1};
      end else begin
         r = v;
      end
      return r;
   endfunction

   // Operand signs at acceptance and one restoring step on the partial remainder.
   always_comb begin
      sign_a_s = (divreq_msg_fn == FN_SIGNED) ? divreq_msg_a[W-1] : 1'b0;
      sign_b_s = (divreq_msg_fn == FN_SIGNED) ? divreq_msg_b[W-1] : 1'b0;
      rem_sh_s = {rem_r, q_r[W-1]};
      diff_s   = {1'b0, rem_sh_s} - {2'b00, b_mag_r};
      // A successful subtraction always leaves less than the divisor, so bit W is clear too.
      nonneg_s = (diff_s[W+1:W] == 2'b00);
      if (nonneg_s) begin
         rem_next_s = diff_s[W-1:0];
         q_next_s   = {q_r[W-2:0], 1'b1};
      end else begin
         rem_next_s = rem_sh_s[W-1:0];
         q_next_s   = {q_r[W-2:0], 1'b0};
      end
   end

   // Control FSM, datapath registers, result fixup and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r            <= IDLE;
         cnt_r              <= {CW{1'b0}};
         sign_a_r           <= 1'b0;
         sign_b_r           <= 1'b0;
         dz_r               <= 1'b0;
         b_mag_r            <= {W{1'b0}};
         rem_r              <= {W{1'b0}};
         q_r                <= {W{1'b0}};
         divreq_rdy         <= 1'b1;
         divresp_val        <= 1'b0;
         divresp_msg_result <= {(2*W){1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (divreq_val && divreq_rdy) begin
                  sign_a_r   <= sign_a_s;
                  sign_b_r   <= sign_b_s;
                  dz_r       <= (divreq_msg_b == {W{1'b0}});
                  q_r        <= cond_neg(divreq_msg_a, sign_a_s);
                  b_mag_r    <= cond_neg(divreq_msg_b, sign_b_s);
                  rem_r      <= {W{1'b0}};
                  cnt_r      <= CW'(W);
                  state_r    <= CALC;
                  divreq_rdy <= 1'b0;
               end
            end
            CALC: begin
               rem_r <= rem_next_s;
               q_r   <= q_next_s;
               cnt_r <= cnt_r - CW'(1);
               if (cnt_r == CW'(1)) begin
                  // With a zero divisor every step subtracts nothing, so the remainder
                  // collects |a| and restoring the dividend sign yields the raw dividend.
                  divresp_msg_result <= {cond_neg(rem_next_s, sign_a_r),
                                         dz_r ? {W{1'b1}} : cond_neg(q_next_s, sign_a_r ^ sign_b_r)};
                  divresp_val        <= 1'b1;
                  state_r            <= DONE;
               end
            end
            DONE: begin
               if (divresp_val && divresp_rdy) begin
                  divresp_val <= 1'b0;
                  divreq_rdy  <= 1'b1;
                  state_r     <= IDLE;
               end
            end
            default: begin
               state_r     <= IDLE;
               cnt_r       <= {CW{1'b0}};
               divreq_rdy  <= 1'b1;
               divresp_val <= 1'b0;
            end
         endcase
      end
   end
endmodule
